// File: rtl/img_rsz_pkg.sv
// Shared resizer types: FSM encoding, entry-count helper, and the default packed pixel type.
// Pure declarations; no timing or backpressure of its own.
package img_rsz_pkg;

    typedef enum logic {
        RSZ_ST_FILL  = 1'b0,
        RSZ_ST_DRAIN = 1'b1
    } rsz_state_e;

    localparam int unsigned RSZ_DEF_PRIM_COLOR_NUM = 1;
    localparam int unsigned RSZ_DEF_PRIM_COLOR_W   = 8;

    // Colour c occupies bits [c*W +: W], matching the compute engine output.
    typedef logic [RSZ_DEF_PRIM_COLOR_NUM*RSZ_DEF_PRIM_COLOR_W-1:0] rsz_pxl_t;

    function automatic int unsigned rsz_entry_num(input int unsigned w, input int unsigned h);
        return w * h;
    endfunction

endpackage

// File: rtl/img_rsz_oh_enc.sv
// One-hot to binary encoder with a flag that is set only for exactly one bit high.
// Purely combinational; no backpressure.
module img_rsz_oh_enc #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] oh_dat,
    output logic [IDX_W-1:0] idx_dat,
    output logic             oh_vld
);

    always_comb begin
        idx_dat = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (oh_dat[i]) begin
                idx_dat = idx_dat | IDX_W'(i);
            end
        end
    end

    // Clearing the lowest set bit leaves zero only for a single-bit mask.
    assign oh_vld = (oh_dat != '0) && ((oh_dat & (oh_dat - WIDTH'(1))) == '0);

endmodule

// File: rtl/img_rsz_pxl_buf.sv
// Captures resized pixels by X/Y mask, pulses RszImgComp when the image is full, then streams it row-major.
// Writes land on the presenting edge; output is valid/ready with one beat per cycle, inputs dropped while draining.
module img_rsz_pxl_buf
    import img_rsz_pkg::*;
#(
    parameter int unsigned RSZ_IMG_WIDTH_SIZE  = 8,
    parameter int unsigned RSZ_IMG_HEIGHT_SIZE = 8,
    parameter int unsigned PXL_PRIM_COLOR_NUM  = 1,
    parameter int unsigned PXL_PRIM_COLOR_W    = 8
) (
    input  logic                                         Clk,
    input  logic                                         ResetN,
    input  logic [PXL_PRIM_COLOR_NUM*PXL_PRIM_COLOR_W-1:0] CeRszPxlData,
    input  logic [RSZ_IMG_WIDTH_SIZE-1:0]                CeRszPxlXMsk,
    input  logic [RSZ_IMG_HEIGHT_SIZE-1:0]               CeRszPxlYMsk,
    input  logic                                         CeCompVld,
    output logic                                         RszImgComp,
    output logic [PXL_PRIM_COLOR_NUM*PXL_PRIM_COLOR_W-1:0] RszPxlData,
    output logic                                         RszPxlVld,
    input  logic                                         RszPxlRdy,
    output logic                                         RszPxlLast,
    output logic                                         BufOvf,
    output logic                                         MskErr
);

    localparam int unsigned ENT_NUM = rsz_entry_num(RSZ_IMG_WIDTH_SIZE, RSZ_IMG_HEIGHT_SIZE);
    localparam int unsigned PXL_W   = PXL_PRIM_COLOR_NUM * PXL_PRIM_COLOR_W;
    localparam int unsigned CNT_W   = $clog2(ENT_NUM + 1);
    localparam int unsigned IDX_W   = (ENT_NUM > 1) ? $clog2(ENT_NUM) : 1;
    localparam int unsigned XI_W    = (RSZ_IMG_WIDTH_SIZE > 1) ? $clog2(RSZ_IMG_WIDTH_SIZE) : 1;
    localparam int unsigned YI_W    = (RSZ_IMG_HEIGHT_SIZE > 1) ? $clog2(RSZ_IMG_HEIGHT_SIZE) : 1;

    rsz_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ENT_NUM-1:0] bmp_q, bmp_d;
    logic [IDX_W-1:0]   rd_idx_q, rd_idx_d;
    logic               comp_q, comp_d;
    logic               ovf_q, ovf_d;
    logic               msk_err_q, msk_err_d;

    logic [PXL_W-1:0]   mem_q [ENT_NUM];

    logic [XI_W-1:0]    x_idx;
    logic [YI_W-1:0]    y_idx;
    logic               x_oh_vld;
    logic               y_oh_vld;
    logic [IDX_W-1:0]   wr_addr;
    logic               wr_en;
    logic               pxl_vld;
    logic               pxl_last;

    img_rsz_oh_enc #(
        .WIDTH (RSZ_IMG_WIDTH_SIZE),
        .IDX_W (XI_W)
    ) u_x_enc (
        .oh_dat  (CeRszPxlXMsk),
        .idx_dat (x_idx),
        .oh_vld  (x_oh_vld)
    );

    img_rsz_oh_enc #(
        .WIDTH (RSZ_IMG_HEIGHT_SIZE),
        .IDX_W (YI_W)
    ) u_y_enc (
        .oh_dat  (CeRszPxlYMsk),
        .idx_dat (y_idx),
        .oh_vld  (y_oh_vld)
    );

    assign wr_addr  = IDX_W'(32'(y_idx) * RSZ_IMG_WIDTH_SIZE + 32'(x_idx));
    assign pxl_vld  = (state_q == RSZ_ST_DRAIN);
    assign pxl_last = pxl_vld && (rd_idx_q == IDX_W'(ENT_NUM - 1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bmp_d     = bmp_q;
        rd_idx_d  = rd_idx_q;
        comp_d    = 1'b0;
        ovf_d     = ovf_q;
        msk_err_d = msk_err_q;
        wr_en     = 1'b0;

        case (state_q)
            RSZ_ST_FILL: begin
                if (CeCompVld) begin
                    if (x_oh_vld && y_oh_vld) begin
                        wr_en = 1'b1;
                        // A rewrite of an already captured location only refreshes data.
                        if (!bmp_q[wr_addr]) begin
                            bmp_d[wr_addr] = 1'b1;
                            cnt_d          = cnt_q + 1'b1;
                            if (cnt_d == CNT_W'(ENT_NUM)) begin
                                state_d  = RSZ_ST_DRAIN;
                                rd_idx_d = '0;
                                comp_d   = 1'b1;
                            end
                        end
                    end else begin
                        msk_err_d = 1'b1;
                    end
                end
            end
            RSZ_ST_DRAIN: begin
                if (CeCompVld) begin
                    ovf_d = 1'b1;
                end
                if (RszPxlRdy) begin
                    if (pxl_last) begin
                        state_d  = RSZ_ST_FILL;
                        bmp_d    = '0;
                        cnt_d    = '0;
                        rd_idx_d = '0;
                    end else begin
                        rd_idx_d = rd_idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = RSZ_ST_FILL;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state_q   <= RSZ_ST_FILL;
            cnt_q     <= '0;
            bmp_q     <= '0;
            rd_idx_q  <= '0;
            comp_q    <= 1'b0;
            ovf_q     <= 1'b0;
            msk_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bmp_q     <= bmp_d;
            rd_idx_q  <= rd_idx_d;
            comp_q    <= comp_d;
            ovf_q     <= ovf_d;
            msk_err_q <= msk_err_d;
        end
    end

    // Pixel storage is deliberately unreset; the bitmap decides what is meaningful.
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= CeRszPxlData;
        end
    end

    assign RszImgComp = comp_q;
    assign RszPxlVld  = pxl_vld;
    assign RszPxlLast = pxl_last;
    assign RszPxlData = pxl_vld ? mem_q[rd_idx_q] : '0;
    assign BufOvf     = ovf_q;
    assign MskErr     = msk_err_q;

endmodule

// File: doc/img_rsz_pxl_buf.md
# img_rsz_pxl_buf

Resized-pixel buffer that sits directly downstream of the resizer compute engine. It captures each resized pixel at the location given by its one-hot X/Y masks. Once every location of the resized image has been written, it pulses the image-complete signal back to the compute engine. It then streams the image out in row-major order over a valid/ready interface.

## Interface
- RSZ_IMG_WIDTH_SIZE, 8: resized image width in pixels; also the X-mask width.
- RSZ_IMG_HEIGHT_SIZE, 8: resized image height in pixels; also the Y-mask width.
- PXL_PRIM_COLOR_NUM, 1: primary colours per pixel.
- PXL_PRIM_COLOR_W, 8: bits per primary colour.
- Clk  in  1  single clock; all logic on posedge.
- ResetN  in  1  asynchronous, active-low reset.
- CeRszPxlData  in  PXL_PRIM_COLOR_NUM*PXL_PRIM_COLOR_W  resized pixel; colour c occupies bits [c*W +: W].
- CeRszPxlXMsk  in  RSZ_IMG_WIDTH_SIZE  one-hot column.
- CeRszPxlYMsk  in  RSZ_IMG_HEIGHT_SIZE  one-hot row.
- CeCompVld  in  1  pixel valid; no backpressure exists, so the pixel is consumed in the same cycle.
- RszImgComp  out  1  one-cycle pulse: image fully captured; drives the compute engine's RszImgComp.
- RszPxlData  out  PXL_PRIM_COLOR_NUM*PXL_PRIM_COLOR_W  output pixel; forced to 0 while RszPxlVld=0.
- RszPxlVld  out  1  output valid.
- RszPxlRdy  in  1  output ready.
- RszPxlLast  out  1  high with the final pixel (index W*H-1).
- BufOvf  out  1  sticky: a pixel arrived during DRAIN and was dropped.
- MskErr  out  1  sticky: a pixel arrived with a non-one-hot mask and was dropped.

## Operation
- Storage: W*H entries of NUM*W bits, plus a W*H-bit written bitmap and a fill counter.
  - Counter width: $clog2(W*H+1).
  - Storage contents are not reset; the bitmap and counter are.
- FSM states: FILL (reset state) and DRAIN.
- FILL behaviour on CeCompVld:
  - Both masks one-hot: write entry Y*W+X.
  - If the bitmap bit was clear, set it and increment the counter.
  - If the bit was already set: overwrite the data; the counter is unchanged.
  - Either mask zero or multi-hot: drop the pixel and set MskErr.
- FILL→DRAIN: taken on the clock edge where the counter reaches W*H.
  - The final write and the transition occur on the same edge.
  - The read index is cleared on that edge.
- DRAIN behaviour:
  - RszPxlVld=1 and RszPxlData = entry[index].
  - Index advances on each RszPxlVld&RszPxlRdy.
  - RszPxlLast = (index == W*H-1).
- DRAIN→FILL: on the handshake of the last pixel.
  - Bitmap, counter and index are cleared on the same edge.
- CeCompVld during DRAIN, including the last-handshake cycle: the pixel is dropped and BufOvf is set.
- BufOvf and MskErr clear only on reset.
- Reset may be asserted at any time, including mid-fill or mid-drain:
  - Outputs and state return to reset values asynchronously.
  - Any partial image is discarded.

## Timing
- Reset values:
  - State = FILL.
  - RszImgComp, RszPxlVld, RszPxlLast, BufOvf, MskErr = 0.
  - RszPxlData = 0.
- Write latency: a pixel presented at edge k is stored at edge k.
- RszImgComp: registered; high for exactly the one cycle after the edge that completes the fill.
- RszPxlVld: rises in the same cycle as RszImgComp, with pixel 0 presented.
- Valid/ready rules:
  - RszPxlVld, RszPxlData and RszPxlLast hold stable until handshake.
  - Vld does not depend on Rdy.
- Throughput: one pixel per cycle when RszPxlRdy=1 continuously.
- Minimum turnaround: fill complete → drain of W*H cycles → FILL on the edge after the last handshake.
  - The next write is accepted in that cycle.

## Structure
- Shared package img_rsz_pkg holds:
  - the FSM enum (FILL, DRAIN);
  - a localparam helper for the entry count W*H;
  - the pixel packing macro/typedef (the same pixel type the compute engine emits).
- One sub-module: img_rsz_oh_enc.
  - One-hot to binary encoder with a "valid one-hot" flag.
  - Parameterised by width.
  - Instantiated twice: X and Y.
- The storage array, bitmap, counter, FSM and output mux live in the top.

## Test plan
Bench configuration unless stated: W=H=2, NUM=3, W=8.
- Reset/idle: hold ResetN=0 then release with no input → all outputs 0 for 20 cycles, state FILL.
- Fill then drain:
  - Stimulus: write (0,0)=0x010203, (1,0)=0x040506, (0,1)=0x070809, (1,1)=0x0A0B0C on consecutive cycles.
  - Response: RszImgComp pulses one cycle after the 4th write.
  - With Rdy=1: 4 beats in order 0x010203, 0x040506, 0x070809, 0x0A0B0C; Last on beat 4 only.
- Duplicate and out-of-order writes:
  - Stimulus: (1,1)=0xAA, then (1,1)=0xBB, then (0,0), (1,0), (0,1).
  - Response: RszImgComp only after the 5th write; entry 3 drains as 0xBB.
- Backpressure: drain with Rdy toggling 1,0,0,1,… → each beat holds data/Last stable while Rdy=0; no beat lost or duplicated.
- Errors:
  - XMsk=2'b11 during FILL → dropped; MskErr=1; counter unchanged.
  - Write during DRAIN → dropped; BufOvf=1; drained data unchanged.
  - Both flags remain set until reset.
- Reset mid-drain:
  - Stimulus: assert ResetN=0 after beat 2.
  - Response: Vld=0 immediately; after release a fresh 4-pixel fill is required before RszImgComp.
